multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/mem_timeout_counter.sv | 38 +++
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multicycle control FSM
//
// Holds the state encoding, the opcode constants the FSM decodes, and the
// immediate, ALU-source, ALU-op and result-select codes driven onto the
// datapath. The JAL state exists only when CTRL_JAL_EN is defined.

package multicycle_control_pkg;

  // State encoding (kept as plain constants so older tools and
  // waveform scripts that expect fixed codes keep working).
  localparam int         STATE_W    = 4;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_LUI      = 4'd10;
`ifdef CTRL_JAL_EN
  localparam logic [3:0] S_JAL      = 4'd11;
`endif
  localparam logic [3:0] S_HALT     = 4'd12;

  // Opcodes (instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate extender select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;

  // ALU A-input select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  // ALU B-input select
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Register-file write-back select
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_IMM     = 2'b10;
  localparam logic [1:0] RES_PC4     = 2'b11;

  // States that hold mem_req and are therefore watched by the timeout.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - watchdog for memory accesses that never complete
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   clear   in   restart the count (entry to a memory-access state)
//   count   in   one more cycle of mem_req without mem_ready
//   expired out  this counted cycle is the TIMEOUT_CYCLES-th one

module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Flagged combinationally during the last allowed wait cycle so the FSM
  // can leave on that edge; a mem_ready in the same cycle drops count and
  // therefore suppresses expiry.
  assign expired = count && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - control FSM for a multicycle RISC-V style datapath
//
// Optional feature: define CTRL_JAL_EN to decode JAL (opcode 1101111);
// otherwise that opcode halts with fault.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset; forces all outputs low
//   opcode[6:0] in   instruction[6:0] from the instruction register
//   zero        in   ALU zero flag (branch condition)
//   mem_ready   in   memory completes the current access this cycle
//   mem_req     out  memory access request, held until mem_ready
//   mem_write   out  access is a store
//   adr_src     out  address select: 0=PC, 1=ALU-out register
//   ir_write    out  instruction register write enable
//   pc_write    out  PC write enable
//   reg_write   out  register file write enable
//   imm_src     out  immediate extender select
//   alu_src_a   out  ALU A-input select
//   alu_src_b   out  ALU B-input select
//   alu_op      out  ALU operation class
//   result_src  out  write-back select
//   fault       out  sticky: illegal opcode or memory timeout

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       fault
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic               fault_q;
  logic               tmo_clear;
  logic               tmo_count;
  logic               tmo_expired;

  // Only the memory-access states can stall, so only they feed the counter.
  assign tmo_count = is_mem_state(state) && !mem_ready;
  assign tmo_clear = (state_next != state) && is_mem_state(state_next);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (tmo_expired) state_next = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_LUI:            state_next = S_LUI;
`ifdef CTRL_JAL_EN
          OP_JAL:            state_next = S_JAL;
`endif
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)        state_next = S_MEMWB;
        else if (tmo_expired) state_next = S_HALT;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)        state_next = S_FETCH;
        else if (tmo_expired) state_next = S_HALT;
      end
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_LUI:      state_next = S_FETCH;
`ifdef CTRL_JAL_EN
      S_JAL:      state_next = S_FETCH;
`endif
      S_HALT:     state_next = S_HALT;
      // Unused encodings are treated like a fault rather than silently
      // resuming execution.
      default:    state_next = S_HALT;
    endcase
  end

  // Every path into HALT is a fault, so the flag simply follows that entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      fault_q <= fault_q || (state_next == S_HALT);
    end
  end

  // Output decode: Moore from state, except the fetch-completion enables
  // (qualified by mem_ready) and the branch pc_write (qualified by zero).
  // Reset forces everything low so an in-flight access is dropped at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_ADD;
    result_src = RES_ALU_OUT;
    fault      = fault_q && !reset;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
          end
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_S;
          alu_op    = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
          imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_REG;
          alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_I;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          result_src = RES_ALU_OUT;
          reg_write  = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = SRC_A_REG;
          alu_src_b  = SRC_B_REG;
          alu_op     = ALU_SUB;
          result_src = RES_ALU_OUT;
          pc_write   = zero;
        end
        S_LUI: begin
          imm_src    = IMM_U;
          result_src = RES_IMM;
          reg_write  = 1'b1;
        end
`ifdef CTRL_JAL_EN
        S_JAL: begin
          imm_src    = IMM_U;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          result_src = RES_PC4;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
  logic       fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .fault      (fault)
  );

  // {fault, req, wr, adr, ir, pc, rw, imm, a, b, op, res}
  function automatic logic [16:0] pk(input logic f, input logic rq, input logic wr,
                                     input logic ad, input logic ir, input logic pc,
                                     input logic rw, input logic [1:0] im,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] rs);
    return {f, rq, wr, ad, ir, pc, rw, im, a, b, op, rs};
  endfunction

  localparam logic [16:0] W_ZERO   = 17'd0;
  localparam logic [16:0] W_F_WAIT = pk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00);
  localparam logic [16:0] W_F_RDY  = pk(0,1,0,0,1,1,0,2'b00,2'b00,2'b10,2'b00,2'b00);
  localparam logic [16:0] W_DEC    = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b01,2'b00,2'b00);
  localparam logic [16:0] W_MA_L   = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00);
  localparam logic [16:0] W_MA_S   = pk(0,0,0,0,0,0,0,2'b01,2'b10,2'b01,2'b00,2'b00);
  localparam logic [16:0] W_MR     = pk(0,1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00);
  localparam logic [16:0] W_MWB    = pk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b01);
  localparam logic [16:0] W_MW     = pk(0,1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00);
  localparam logic [16:0] W_ER     = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00);
  localparam logic [16:0] W_EI     = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00);
  localparam logic [16:0] W_AWB    = pk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00);
  localparam logic [16:0] W_BEQ1   = pk(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,2'b00);
  localparam logic [16:0] W_BEQ0   = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b00);
  localparam logic [16:0] W_LUI    = pk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,2'b10);
  localparam logic [16:0] W_JAL    = pk(0,0,0,0,0,1,1,2'b10,2'b00,2'b00,2'b00,2'b11);
  localparam logic [16:0] W_HALT   = pk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00);

  logic [16:0] obs;
  assign obs = {fault, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_op, result_src};

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %05h want %05h", tag, got, want);
    end
  endtask

  // One clock: sample mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] want);
    @(negedge clk);
    check(tag, obs, want);
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input string tag, input logic [16:0] want, input int n);
    for (int i = 0; i < n; i++) cyc($sformatf("%s[%0d]", tag, i), want);
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0; zero = 1'b0; mem_ready = 1'b1;
    cycn("reset_outputs", W_ZERO, 2);
    reset = 1'b0;

    // lw, two wait cycles on each access
    opcode = 7'b0000011; mem_ready = 1'b0;
    cycn("lw_fetch_wait", W_F_WAIT, 2);
    mem_ready = 1'b1; cyc("lw_fetch_rdy", W_F_RDY);
    mem_ready = 1'b0;
    cyc("lw_decode", W_DEC);
    cyc("lw_memadr", W_MA_L);
    cycn("lw_memread_wait", W_MR, 2);
    mem_ready = 1'b1; cyc("lw_memread_rdy", W_MR);
    cyc("lw_memwb", W_MWB);

    // sw, memory always ready
    opcode = 7'b0100011;
    cyc("sw_fetch", W_F_RDY);
    cyc("sw_decode", W_DEC);
    cyc("sw_memadr", W_MA_S);
    cyc("sw_memwrite", W_MW);

    // add (R-type)
    opcode = 7'b0110011;
    cyc("r_fetch", W_F_RDY);
    cyc("r_decode", W_DEC);
    cyc("r_exec", W_ER);
    cyc("r_aluwb", W_AWB);

    // addi (I-type)
    opcode = 7'b0010011;
    cyc("i_fetch", W_F_RDY);
    cyc("i_decode", W_DEC);
    cyc("i_exec", W_EI);
    cyc("i_aluwb", W_AWB);

    // beq taken, then not taken
    opcode = 7'b1100011; zero = 1'b1;
    cyc("beq1_fetch", W_F_RDY);
    cyc("beq1_decode", W_DEC);
    cyc("beq_taken", W_BEQ1);
    zero = 1'b0;
    cyc("beq0_fetch", W_F_RDY);
    cyc("beq0_decode", W_DEC);
    cyc("beq_not_taken", W_BEQ0);

    // lui
    opcode = 7'b0110111;
    cyc("lui_fetch", W_F_RDY);
    cyc("lui_decode", W_DEC);
    cyc("lui", W_LUI);

    // lw with mem_ready arriving on the 16th wait cycle: no timeout
    opcode = 7'b0000011;
    cyc("edge_fetch", W_F_RDY);
    cyc("edge_decode", W_DEC);
    cyc("edge_memadr", W_MA_L);
    mem_ready = 1'b0;
    cycn("edge_memread_wait", W_MR, 15);
    mem_ready = 1'b1; cyc("edge_memread_16th", W_MR);
    cyc("edge_memwb_no_fault", W_MWB);

    // lw with mem_ready never arriving: HALT after 16 cycles
    cyc("tmo_fetch", W_F_RDY);
    cyc("tmo_decode", W_DEC);
    cyc("tmo_memadr", W_MA_L);
    mem_ready = 1'b0;
    cycn("tmo_memread", W_MR, 16);
    mem_ready = 1'b1;
    cycn("tmo_halt", W_HALT, 11);
    reset = 1'b1; cyc("tmo_reset", W_ZERO);
    reset = 1'b0; mem_ready = 1'b0;
    cyc("tmo_after_reset", W_F_WAIT);

    // jal: decoded only with CTRL_JAL_EN
    opcode = 7'b1101111; mem_ready = 1'b1;
    cyc("jal_fetch", W_F_RDY);
    cyc("jal_decode", W_DEC);
`ifdef CTRL_JAL_EN
    cyc("jal", W_JAL);
    mem_ready = 1'b0;
    cyc("jal_next_fetch", W_F_WAIT);
`else
    cycn("jal_halt", W_HALT, 3);
`endif
    // reset in the middle of a fetch (or in HALT) drops everything at once
    reset = 1'b1; cyc("mid_reset", W_ZERO);
    reset = 1'b0; mem_ready = 1'b1;

    // illegal opcode
    opcode = 7'b1111111;
    cyc("ill_fetch", W_F_RDY);
    cyc("ill_decode", W_DEC);
    cycn("ill_halt", W_HALT, 12);
    reset = 1'b1; cyc("ill_reset", W_ZERO);
    reset = 1'b0; mem_ready = 1'b0;
    cyc("ill_after_reset", W_F_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
